// File: rtl/snn_video_pkg.sv
// Shared timing constants and helpers for the SNN video path.
// Defaults describe 640x480@60 raster timing.
package snn_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX counter: counts 0..MAX-1 on inc and flags the wrap cycle.
// wrap is combinational so a following counter can chain on it in the same cycle.
module wrap_counter
    import snn_video_pkg::*;
#(
    parameter int MAX = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc,
    output logic [cnt_width(MAX)-1:0] cnt,
    output logic                      wrap
);

    localparam int            W    = cnt_width(MAX);
    localparam logic [W-1:0]  LAST = W'(MAX - 1);

    assign wrap = inc && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: hs/vs/de, active-pixel coordinates and the
// per-frame (or per-line) neuron_reset pulse, all registered one clk after the counters.
module video_timing_gen
    import snn_video_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter bit HS_POL       = POL_ACTIVE_LOW,
    parameter bit VS_POL       = POL_ACTIVE_LOW,
    parameter bit RST_PER_LINE = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    output logic                           hs_out,
    output logic                           vs_out,
    output logic                           de_out,
    output logic                           neuron_reset,
    output logic                           frame_start,
    output logic [cnt_width(H_ACTIVE)-1:0] x,
    output logic [cnt_width(V_ACTIVE)-1:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int XW      = cnt_width(H_ACTIVE);
    localparam int YW      = cnt_width(V_ACTIVE);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_ACTIVE < 2 || V_ACTIVE < 2 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
            $error("video_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;

    wrap_counter #(.MAX(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    // The vertical counter advances only on the horizontal wrap cycle.
    wrap_counter #(.MAX(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap_unused)
    );

    logic          h_active, v_active, de_next;
    logic          hs_asserted, vs_asserted;
    logic          line_start, origin, pulse_next;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    assign h_active    = h_cnt < H_ACT_END;
    assign v_active    = v_cnt < V_ACT_END;
    assign de_next     = h_active && v_active;
    assign hs_asserted = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_asserted = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign line_start  = (h_cnt == '0);
    assign origin      = line_start && (v_cnt == '0);
    assign pulse_next  = RST_PER_LINE ? (line_start && v_active) : origin;
    assign x_next      = de_next ? h_cnt[XW-1:0] : '0;
    assign y_next      = de_next ? v_cnt[YW-1:0] : '0;

    // While en is low the levels hold but the pulses drop, so a pulse never stretches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_out       <= ~HS_POL;
            vs_out       <= ~VS_POL;
            de_out       <= 1'b0;
            neuron_reset <= 1'b0;
            frame_start  <= 1'b0;
            x            <= '0;
            y            <= '0;
        end else if (en) begin
            hs_out       <= hs_asserted ? HS_POL : ~HS_POL;
            vs_out       <= vs_asserted ? VS_POL : ~VS_POL;
            de_out       <= de_next;
            neuron_reset <= pulse_next;
            frame_start  <= origin;
            x            <= x_next;
            y            <= y_next;
        end else begin
            neuron_reset <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a 16x8 raster, with a
// position-based reference model plus directed literal checks.
module tb_video_timing_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic clk, rst_n, en;
    logic hs_a, vs_a, de_a, nr_a, fs_a;
    logic hs_b, vs_b, de_b, nr_b, fs_b;
    logic [2:0] x_a, x_b;
    logic [1:0] y_a, y_b;

    int total = 0;
    int bad   = 0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RST_PER_LINE(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hs_out(hs_a), .vs_out(vs_a), .de_out(de_a),
        .neuron_reset(nr_a), .frame_start(fs_a), .x(x_a), .y(y_a)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RST_PER_LINE(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hs_out(hs_b), .vs_out(vs_b), .de_out(de_b),
        .neuron_reset(nr_b), .frame_start(fs_b), .x(x_b), .y(y_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pos is the raster position (h + v*HT) about to be registered.
    function automatic int f_h(input int p); return p % HT; endfunction
    function automatic int f_v(input int p); return p / HT; endfunction
    function automatic bit f_de(input int p); return (f_h(p) < HA) && (f_v(p) < VA); endfunction
    function automatic bit f_hs(input int p);
        return !((f_h(p) >= HA + HFP) && (f_h(p) < HA + HFP + HS));
    endfunction
    function automatic bit f_vs(input int p);
        return !((f_v(p) >= VA + VFP) && (f_v(p) < VA + VFP + VS));
    endfunction

    int         pos;
    logic       m_hs, m_vs, m_de, m_nr_a, m_nr_b, m_fs;
    logic [2:0] m_x;
    logic [1:0] m_y;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 0;
            m_hs <= 1'b1; m_vs <= 1'b1; m_de <= 1'b0;
            m_nr_a <= 1'b0; m_nr_b <= 1'b0; m_fs <= 1'b0;
            m_x <= '0; m_y <= '0;
        end else if (en) begin
            pos    <= (pos + 1) % FRAME;
            m_hs   <= f_hs(pos);
            m_vs   <= f_vs(pos);
            m_de   <= f_de(pos);
            m_nr_a <= (pos == 0);
            m_nr_b <= (f_h(pos) == 0) && (f_v(pos) < VA);
            m_fs   <= (pos == 0);
            m_x    <= f_de(pos) ? 3'(f_h(pos)) : 3'd0;
            m_y    <= f_de(pos) ? 2'(f_v(pos)) : 2'd0;
        end else begin
            m_nr_a <= 1'b0;
            m_nr_b <= 1'b0;
            m_fs   <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("hs",   hs_a,   m_hs);
            check("vs",   vs_a,   m_vs);
            check("de",   de_a,   m_de);
            check("nr_a", nr_a,   m_nr_a);
            check("fs_a", fs_a,   m_fs);
            check("x",    32'(x_a), 32'(m_x));
            check("y",    32'(y_a), 32'(m_y));
            check("nr_b", nr_b,   m_nr_b);
            check("fs_b", fs_b,   m_fs);
            check("de_b", de_b,   m_de);
        end
    end

    task automatic sample_frame(output int n_nr_a, output int n_nr_b, output int n_fs_a,
                                output int n_fs_b, output int n_de, output int n_hs,
                                output int n_vs, output int n_ovl);
        n_nr_a = 0; n_nr_b = 0; n_fs_a = 0; n_fs_b = 0;
        n_de = 0; n_hs = 0; n_vs = 0; n_ovl = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_nr_a += int'(nr_a);
            n_nr_b += int'(nr_b);
            n_fs_a += int'(fs_a);
            n_fs_b += int'(fs_b);
            n_de   += int'(de_a);
            n_hs   += int'(!hs_a);
            n_vs   += int'(!vs_a);
            n_ovl  += int'(de_a && !hs_a);
        end
    endtask

    task automatic wait_pixel(input int wx, input int wy, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (de_a && int'(x_a) == wx && int'(y_a) == wy) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    int c_nr_a, c_nr_b, c_fs_a, c_fs_b, c_de, c_hs, c_vs, c_ovl;

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hs", hs_a, 1'b1);
        check("rst_vs", vs_a, 1'b1);
        check("rst_de", de_a, 1'b0);
        check("rst_nr", nr_a, 1'b0);
        check("rst_x",  32'(x_a), 32'd0);
        #1 rst_n = 1'b1; en = 1'b1;

        // One full frame from the origin.
        sample_frame(c_nr_a, c_nr_b, c_fs_a, c_fs_b, c_de, c_hs, c_vs, c_ovl);
        check("frame_nr_a", c_nr_a, 1);
        check("frame_nr_b", c_nr_b, 4);
        check("frame_fs_a", c_fs_a, 1);
        check("frame_fs_b", c_fs_b, 1);
        check("frame_de",   c_de,   32);
        check("frame_hs",   c_hs,   24);
        check("frame_vs",   c_vs,   32);
        check("hs_in_de",   c_ovl,  0);

        // Wrap boundary: the 129th sample is the next origin.
        @(negedge clk);
        check("wrap_nr", nr_a, 1'b1);
        check("wrap_de", de_a, 1'b1);
        check("wrap_xy", {29'd0, x_a} | 32'(y_a), 32'd0);

        // Freeze at (5,2) for 7 cycles, then resume.
        wait_pixel(5, 2, "wait_5_2");
        #1 en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_x",  32'(x_a), 32'd5);
            check("hold_y",  32'(y_a), 32'd2);
            check("hold_nr", nr_a, 1'b0);
        end
        #1 en = 1'b1;
        @(negedge clk);
        check("resume_x6", 32'(x_a), 32'd6);
        @(negedge clk);
        check("resume_x7", 32'(x_a), 32'd7);
        @(negedge clk);
        check("resume_de", de_a, 1'b0);

        // Asynchronous reset while de is high.
        wait_pixel(3, 3, "wait_3_3");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_de", de_a, 1'b0);
        check("arst_x",  32'(x_a), 32'd0);
        check("arst_hs", hs_a, 1'b1);
        check("arst_vs", vs_a, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_nr", nr_a, 1'b1);
        check("rel_fs", fs_a, 1'b1);
        check("rel_de", de_a, 1'b1);
        sample_frame(c_nr_a, c_nr_b, c_fs_a, c_fs_b, c_de, c_hs, c_vs, c_ovl);
        check("rel_frame_nr", c_nr_a, 1);
        check("rel_last_nr",  nr_a, 1'b1);

        // Randomised enable with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end else begin
                @(negedge clk);
                #1 en = ($urandom_range(0, 3) != 0);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
